// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit word-addressed pipeline.
package pipe_pkg;

  typedef logic [15:0] word_t;

  localparam word_t RESET_PC  = 16'h3000;
  localparam word_t NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } if_state_t;

  function automatic word_t inc(input word_t a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry {instr, pc1} buffer parking a fetch that lands during a stall.
module if_hold_buffer
  import pipe_pkg::*;
(
  input  logic  CLK,
  input  logic  RESET,
  input  logic  load,
  input  logic  unload,
  input  logic  flush,
  input  word_t ld_instr,
  input  word_t ld_pc1,
  output logic  full,
  output word_t instr,
  output word_t pc1
);

  logic  full_q;
  word_t instr_q;
  word_t pc1_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc1_q   <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q  <= 1'b1;
      instr_q <= ld_instr;
      pc1_q   <= ld_pc1;
    end else if (unload) begin
      full_q <= 1'b0;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc1   = pc1_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID register with
// variable-latency imem handshake, stall hold and branch drain.
module if_stage #(
  parameter pipe_pkg::word_t RESET_PC  = pipe_pkg::RESET_PC,
  parameter pipe_pkg::word_t NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH,
  input  logic [15:0] BR_PC,
  input  logic [15:0] BR_OFFSET,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic [15:0] IMEM_RDATA,
  input  logic        IMEM_READY,
  output logic [15:0] IR,
  output logic [15:0] PC_OUT,
  output logic        VALID
);

  import pipe_pkg::*;

  if_state_t state_q, state_d;
  word_t     pc_q, pc_d;
  word_t     ir_q, ir_d;
  word_t     pc1_q, pc1_d;
  logic      valid_q, valid_d;
  word_t     daddr_q, daddr_d;
  word_t     pc_inc;

  logic  hb_load, hb_unload, hb_flush, hb_full;
  word_t hb_instr, hb_pc1;

  assign pc_inc = inc(pc_q);

  if_hold_buffer u_hb (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (hb_load),
    .unload   (hb_unload),
    .flush    (hb_flush),
    .ld_instr (IMEM_RDATA),
    .ld_pc1   (pc_inc),
    .full     (hb_full),
    .instr    (hb_instr),
    .pc1      (hb_pc1)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pc1_d     = pc1_q;
    valid_d   = valid_q;
    daddr_d   = daddr_q;
    hb_load   = 1'b0;
    hb_unload = 1'b0;
    hb_flush  = 1'b0;
    if (BRANCH) begin
      pc_d     = BR_PC + BR_OFFSET;
      ir_d     = NOP_INSTR;
      valid_d  = 1'b0;
      hb_flush = 1'b1;
      state_d  = FETCH;
      // An unfinished request must be drained on its old address.
      if (state_q == FETCH && !IMEM_READY) begin
        state_d = DRAIN;
        daddr_d = pc_q;
      end else if (state_q == DRAIN && !IMEM_READY) begin
        state_d = DRAIN;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (STALL) begin
            if (IMEM_READY) begin
              hb_load = 1'b1;
              pc_d    = pc_inc;
              state_d = HOLD;
            end
          end else if (IMEM_READY) begin
            ir_d    = IMEM_RDATA;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end else begin
            ir_d    = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!STALL && hb_full) begin
            ir_d      = hb_instr;
            pc1_d     = hb_pc1;
            valid_d   = 1'b1;
            hb_unload = 1'b1;
            state_d   = FETCH;
          end
        end
        DRAIN: begin
          ir_d    = NOP_INSTR;
          valid_d = 1'b0;
          if (IMEM_READY) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      daddr_q <= daddr_d;
    end
  end

  assign IMEM_REQ  = !RESET && (state_q != HOLD);
  assign IMEM_ADDR = (state_q == DRAIN) ? daddr_q : pc_q;
  assign IR        = ir_q;
  assign PC_OUT    = pc1_q;
  assign VALID     = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a mem[a]=a^5A5A instruction memory.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        BRANCH;
  logic [15:0] BR_PC;
  logic [15:0] BR_OFFSET;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic [15:0] IMEM_RDATA;
  logic        IMEM_READY;
  logic [15:0] IR;
  logic [15:0] PC_OUT;
  logic        VALID;

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .STALL      (STALL),
    .BRANCH     (BRANCH),
    .BR_PC      (BR_PC),
    .BR_OFFSET  (BR_OFFSET),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_RDATA (IMEM_RDATA),
    .IMEM_READY (IMEM_READY),
    .IR         (IR),
    .PC_OUT     (PC_OUT),
    .VALID      (VALID)
  );

  always #5 CLK = ~CLK;

  assign IMEM_RDATA = IMEM_ADDR ^ 16'h5A5A;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; STALL = 1'b0; BRANCH = 1'b0;
    BR_PC = '0; BR_OFFSET = '0; IMEM_READY = 1'b1;
    step();
    step();
    total++;
    if (IMEM_REQ !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b exp=0", IMEM_REQ);
    end
    total++;
    if (VALID !== 1'b0 || IR !== 16'h0000 || PC_OUT !== 16'h0000) begin
      bad++;
      $display("FAIL rst_ifid got=%b/%h/%h exp=0/0000/0000",
               VALID, IR, PC_OUT);
    end
    RESET = 1'b0;
    #1;
    total++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h3000) begin
      bad++;
      $display("FAIL rst_first got=%b/%h exp=1/3000", IMEM_REQ, IMEM_ADDR);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_ir [3];
    exp_ir[0] = 16'h6A5A; exp_ir[1] = 16'h6A5B; exp_ir[2] = 16'h6A58;
    IMEM_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (IMEM_ADDR !== 16'h3000 + 16'(i) || IMEM_REQ !== 1'b1) begin
        bad++;
        $display("FAIL b2b_addr%0d got=%h exp=%h", i, IMEM_ADDR,
                 16'h3000 + 16'(i));
      end
      step();
      total++;
      if (IR !== exp_ir[i] || PC_OUT !== 16'h3001 + 16'(i) ||
          VALID !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ifid%0d got=%h/%h/%b exp=%h/%h/1", i, IR,
                 PC_OUT, VALID, exp_ir[i], 16'h3001 + 16'(i));
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    IMEM_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h3000) begin
        bad++;
        $display("FAIL wait_req%0d got=%b/%h exp=1/3000", i, IMEM_REQ,
                 IMEM_ADDR);
      end
      step();
      total++;
      if (IR !== 16'h0000 || VALID !== 1'b0) begin
        bad++;
        $display("FAIL wait_bubble%0d got=%h/%b exp=0000/0", i, IR, VALID);
      end
    end
    IMEM_READY = 1'b1;
    step();
    total++;
    if (IR !== 16'h6A5A || PC_OUT !== 16'h3001 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL wait_fill got=%h/%h/%b exp=6A5A/3001/1", IR, PC_OUT,
               VALID);
    end
  endtask

  task automatic test_stall();
    do_reset();
    IMEM_READY = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (IMEM_ADDR !== 16'h3005 || IR !== 16'h6A5E) begin
      bad++;
      $display("FAIL stall_pre got=%h/%h exp=3005/6A5E", IMEM_ADDR, IR);
    end
    STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (IR !== 16'h6A5E || PC_OUT !== 16'h3005 || VALID !== 1'b1) begin
        bad++;
        $display("FAIL stall_frozen%0d got=%h/%h/%b exp=6A5E/3005/1", i,
                 IR, PC_OUT, VALID);
      end
      total++;
      if (IMEM_REQ !== 1'b0) begin
        bad++; $display("FAIL stall_hold_req%0d got=%b exp=0", i, IMEM_REQ);
      end
    end
    STALL = 1'b0;
    step();
    total++;
    if (IR !== 16'h6A5F || PC_OUT !== 16'h3006 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got=%h/%h/%b exp=6A5F/3006/1", IR,
               PC_OUT, VALID);
    end
    total++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h3006) begin
      bad++;
      $display("FAIL stall_restart got=%b/%h exp=1/3006", IMEM_REQ,
               IMEM_ADDR);
    end
    step();
    total++;
    if (IR !== 16'h6A5C || PC_OUT !== 16'h3007) begin
      bad++;
      $display("FAIL stall_next got=%h/%h exp=6A5C/3007", IR, PC_OUT);
    end
  endtask

  task automatic test_branch_idle();
    IMEM_READY = 1'b1;
    BRANCH = 1'b1; BR_PC = 16'h3010; BR_OFFSET = 16'hFFF0;
    step();
    BRANCH = 1'b0;
    #1;
    total++;
    if (IR !== 16'h0000 || VALID !== 1'b0) begin
      bad++; $display("FAIL br_squash got=%h/%b exp=0000/0", IR, VALID);
    end
    total++;
    if (IMEM_ADDR !== 16'h3000 || IMEM_REQ !== 1'b1) begin
      bad++;
      $display("FAIL br_target got=%b/%h exp=1/3000", IMEM_REQ, IMEM_ADDR);
    end
    step();
    total++;
    if (IR !== 16'h6A5A || PC_OUT !== 16'h3001 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL br_fill got=%h/%h/%b exp=6A5A/3001/1", IR, PC_OUT,
               VALID);
    end
  endtask

  task automatic test_branch_drain();
    do_reset();
    IMEM_READY = 1'b0;
    BRANCH = 1'b1; BR_PC = 16'h3004; BR_OFFSET = 16'h0005;
    step();
    BRANCH = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) IMEM_READY = 1'b1;
      #1;
      total++;
      if (IMEM_ADDR !== 16'h3000 || IMEM_REQ !== 1'b1) begin
        bad++;
        $display("FAIL drain_addr%0d got=%b/%h exp=1/3000", i, IMEM_REQ,
                 IMEM_ADDR);
      end
      step();
      total++;
      if (IR !== 16'h0000 || VALID !== 1'b0) begin
        bad++;
        $display("FAIL drain_drop%0d got=%h/%b exp=0000/0", i, IR, VALID);
      end
    end
    total++;
    if (IMEM_ADDR !== 16'h3009 || IMEM_REQ !== 1'b1) begin
      bad++;
      $display("FAIL drain_redir got=%b/%h exp=1/3009", IMEM_REQ,
               IMEM_ADDR);
    end
    step();
    total++;
    if (IR !== 16'h6A53 || PC_OUT !== 16'h300A || VALID !== 1'b1) begin
      bad++;
      $display("FAIL drain_fill got=%h/%h/%b exp=6A53/300A/1", IR, PC_OUT,
               VALID);
    end
  endtask

  task automatic test_wrap_reset();
    IMEM_READY = 1'b1;
    BRANCH = 1'b1; BR_PC = 16'hFFF0; BR_OFFSET = 16'h000F;
    step();
    BRANCH = 1'b0;
    #1;
    total++;
    if (IMEM_ADDR !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_addr got=%h exp=FFFF", IMEM_ADDR);
    end
    step();
    total++;
    if (IR !== 16'hA5A5 || PC_OUT !== 16'h0000 || VALID !== 1'b1) begin
      bad++;
      $display("FAIL wrap_fill got=%h/%h/%b exp=A5A5/0000/1", IR, PC_OUT,
               VALID);
    end
    total++;
    if (IMEM_ADDR !== 16'h0000) begin
      bad++; $display("FAIL wrap_next got=%h exp=0000", IMEM_ADDR);
    end
    IMEM_READY = 1'b0;
    BRANCH = 1'b1; BR_PC = 16'h0100; BR_OFFSET = 16'h0000;
    step();
    BRANCH = 1'b0;
    #1;
    total++;
    if (IMEM_ADDR !== 16'h0000 || IMEM_REQ !== 1'b1) begin
      bad++;
      $display("FAIL rdrain_addr got=%b/%h exp=1/0000", IMEM_REQ,
               IMEM_ADDR);
    end
    RESET = 1'b1;
    #1;
    total++;
    if (IMEM_REQ !== 1'b0) begin
      bad++; $display("FAIL rdrain_req got=%b exp=0", IMEM_REQ);
    end
    step();
    RESET = 1'b0;
    #1;
    total++;
    if (IMEM_ADDR !== 16'h3000 || VALID !== 1'b0 || IMEM_REQ !== 1'b1) begin
      bad++;
      $display("FAIL rdrain_pc got=%h/%b/%b exp=3000/0/1", IMEM_ADDR,
               VALID, IMEM_REQ);
    end
    IMEM_READY = 1'b1;
    step();
    total++;
    if (IR !== 16'h6A5A || PC_OUT !== 16'h3001) begin
      bad++;
      $display("FAIL rdrain_fill got=%h/%h exp=6A5A/3001", IR, PC_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_stall();
    test_branch_idle();
    test_branch_drain();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage and IF/ID pipeline register of the 16-bit, word-addressed 5-stage pipeline.
- Sits directly upstream of decode and supplies it with IR and PC_OUT (the incremented PC).
- Obeys decode's STALL and BRANCH outputs. Computes the branch target from decode's PC and 9-bit PC offset.
- Talks to instruction memory through a variable-latency req/ready handshake.

Parameters:
- RESET_PC, 16'h3000, PC loaded on reset.
- NOP_INSTR, 16'h0000, bubble encoding (BR with nzp=000, never taken).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- STALL  input  1  from decode; hold the IF/ID register.
- BRANCH  input  1  from decode; redirect fetch, squash IF/ID.
- BR_PC  input  16  decode's PC_OUT for the branch instruction.
- BR_OFFSET  input  16  decode's sign-extended PC offset.
- IMEM_REQ  output  1  fetch request.
- IMEM_ADDR  output  16  fetch address.
- IMEM_RDATA  input  16  instruction data; valid when IMEM_READY=1.
- IMEM_READY  input  1  request completes this cycle.
- IR  output  16  IF/ID instruction register.
- PC_OUT  output  16  IF/ID PC+1 of the instruction in IR.
- VALID  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (RESET=1 at posedge):
  - PC<=RESET_PC, IR<=NOP_INSTR, PC_OUT<=16'h0000, VALID<=0.
  - Hold buffer empty; state<=FETCH.
  - IMEM_REQ is 0 while RESET is high.
  - Reset overrides all other inputs, including mid-request. Memory must tolerate an abandoned request.
- States: FETCH, HOLD, DRAIN.
- Handshake:
  - IMEM_REQ=1 in FETCH and DRAIN.
  - In FETCH, IMEM_ADDR=PC. In DRAIN, IMEM_ADDR=the latched outstanding address.
  - Once raised, REQ and ADDR stay stable until a cycle with IMEM_READY=1. The transfer completes at that posedge.
  - Zero-wait memory (READY in the same cycle as REQ) gives one instruction per cycle.
- FETCH, BRANCH=0, STALL=0:
  - READY=1: IR<=RDATA, PC_OUT<=PC+1, VALID<=1, PC<=PC+1.
  - READY=0: IR<=NOP_INSTR, VALID<=0 (bubble), PC unchanged.
- FETCH, STALL=1, BRANCH=0:
  - IF/ID holds all values.
  - READY=1: capture RDATA and PC+1 into the hold buffer, PC<=PC+1, state<=HOLD.
- HOLD:
  - IMEM_REQ=0.
  - STALL=1: nothing changes.
  - STALL=0: IR/PC_OUT<=buffer, VALID<=1, buffer empties, state<=FETCH. The next fetch issues in the following cycle.
- BRANCH=1 (priority over STALL, in any state):
  - PC<=BR_PC+BR_OFFSET, mod 2^16.
  - IR<=NOP_INSTR, VALID<=0; the hold buffer is discarded.
  - If in FETCH with READY=0 (request outstanding): state<=DRAIN.
  - Otherwise state<=FETCH, and the returning data (if READY=1) is dropped.
  - Decode deasserts BRANCH the next cycle because IR is now a NOP.
- DRAIN:
  - Keep REQ asserted on the old address until READY. Discard the data, load nothing, VALID<=0.
  - On READY, state<=FETCH at the redirected PC.
  - A BRANCH in DRAIN overwrites PC with the new target and stays in DRAIN.
- Arithmetic and width:
  - PC+1 wraps 16'hFFFF -> 16'h0000.
  - Target addition is 16-bit with no overflow flag.
  - PC_OUT always equals the fetch address of IR plus 1.
- Throughput: one instruction per cycle with zero-wait memory and no hazards. A stall release costs one bubble-free transfer plus one restart cycle.

Decomposition:
- Shared package pipe_pkg:
  - if_state_t enum (FETCH, HOLD, DRAIN).
  - NOP_INSTR and RESET_PC constants.
  - 16-bit word type.
- One sub-module: if_hold_buffer.
  - One-entry {instr, pc1} register with load, release and flush.
  - Flush has priority over load.
  - Synchronous reset to empty.

Test Plan:
- Reset then zero-wait memory where mem[a]=a^16'h5A5A -> IMEM_ADDR sequence 3000,3001,3002. IR 16'h6A5A with PC_OUT 3001 one cycle after the first request; VALID=1 from the first fill.
- READY delayed 3 cycles on address 3000 -> REQ/ADDR stable 3 cycles, IR=NOP and VALID=0 during them, then IR=mem[3000].
- STALL high for 4 cycles while READY returns mem[3005] -> IF/ID frozen, REQ low in HOLD. On release, IR=mem[3005], PC_OUT=3006, next ADDR=3006.
- BRANCH with BR_PC=3010, BR_OFFSET=16'hFFF0 while no request is outstanding -> IR=NOP, VALID=0, next ADDR=3000.
- BRANCH during an outstanding request (READY low 2 more cycles), BR_PC=3004, BR_OFFSET=0005 -> ADDR stays at the old address until READY, data dropped, then ADDR=3009 with no stale instruction reaching IR.
- Wrap and reset: PC=FFFF fetch gives PC_OUT=0000 and next ADDR=0000. Asserting RESET mid-DRAIN -> next cycle PC=3000, VALID=0, REQ=0.
